mem_wait_ctrl: RTL and testbench
================================

// Module: mem_wait_ctrl
// PURPOSE
// - Parametrised single-port word RAM with valid/ready request handshake and programmable wait states.
// - Next-generation data/instruction memory for the accumulator CPU.
// - CPU issues one read or write per request and receives a one-cycle response pulse (read data or write ack).
// - Out-of-range addresses are flagged, not aliased.
// PARAMETERS
// - DATA_W  16    word width in bits (multiple of 8)
// - ADDR_W  11    request address width
// - DEPTH   2048  implemented words, 1..2**ADDR_W; addresses >= DEPTH are out of range
// - WAIT    2     wait-state cycles inserted before the access, 0..15
// PORTS
// - clk        in   1          clock, all state updates on rising edge
// - rst        in   1          asynchronous, active-high reset
// - req_valid  in   1          request present
// - req_ready  out  1          block can accept a request this cycle
// - req_write  in   1          1 = write, 0 = read
// - req_addr   in   ADDR_W     word address
// - req_wdata  in   DATA_W     write data
// - req_be     in   DATA_W/8   byte write enables (only with MEM_BYTE_WRITE_EN)
// - rsp_valid  out  1          one-cycle response pulse
// - rsp_rdata  out  DATA_W     read data, valid with rsp_valid on reads
// - rsp_err    out  1          address out of range, valid with rsp_valid
// - busy       out  1          request in flight (state != IDLE)
// BEHAVIOUR
// - Reset: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0.
// - Reset: req_ready 1 once rst deasserts. RAM contents are not cleared.
// - FSM states: IDLE, WAIT, ACCESS.
//   - req_ready = (state == IDLE).
//   - Accept when req_valid & req_ready at a rising edge. Latch write, addr, wdata (and be).
//   - Inputs are ignored after accept.
// - IDLE -> WAIT on accept with cnt = WAIT. If WAIT == 0, IDLE -> ACCESS directly.
// - WAIT: cnt decrements each cycle. WAIT -> ACCESS on the edge where cnt == 1.
// - ACCESS -> IDLE on the next edge. That same edge:
//   - performs the RAM operation;
//   - sets rsp_valid = 1 and rsp_err = (addr >= DEPTH);
//   - on a read, loads rsp_rdata.
// - Latency: accept at edge E0 -> rsp_valid high in the cycle after edge E0 + WAIT + 1.
// - Throughput: one request per WAIT + 2 cycles. The next request may be accepted in the rsp_valid cycle.
// - rsp_valid is high for exactly one cycle, with no response backpressure. rsp_rdata and rsp_err hold until the next response.
// - Write: rsp_rdata is unchanged. rsp_valid acts as the write acknowledge.
// - Out-of-range: the write is suppressed and RAM is unchanged. A read returns rsp_rdata = 0. rsp_err = 1 in both cases.
// - Address compare is done at ADDR_W + 1 bits, so DEPTH == 2**ADDR_W never flags.
// - Read after write to the same address returns the new data. Both are separate requests, so there is no bypass hazard.
// - rst asserted mid-request: the request is aborted, a pending write is NOT performed, outputs take reset values immediately.
// - req_valid while busy: not accepted. The requester must hold it; the block adds no queueing.
// CONFIGURATION
// - MEM_BYTE_WRITE_EN defined:
//   - req_be port exists. On a write, byte lane i = data[8i+7:8i] is updated only if req_be[i] = 1.
//   - A write with be == 0 still acks, with rsp_err per the range check.
// - MEM_BYTE_WRITE_EN undefined:
//   - no req_be port; every write updates the full word.
// TESTING
// - WAIT=2: write 0x1815 to addr 21, then read addr 21 -> rsp_valid 3 cycles after each accept, rdata 0x1815, err 0.
// - WAIT=0: back-to-back reads of addr 10/11 preloaded 0x0009/0xFFFC -> one response every 2 cycles, data in order.
// - DEPTH=64: write 0xBEEF to addr 64 -> err 1, no write. Then read addr 0 -> unchanged. Read addr 64 -> rdata 0, err 1.
// - rst pulse during WAIT of a write of 0x1234 to addr 5 -> no rsp_valid; later read of addr 5 returns the old value.
// - req_valid held while busy, req_addr changed mid-flight -> only the latched address is accessed; the second request is accepted on the rsp_valid cycle.
// - MEM_BYTE_WRITE_EN: addr 3 = 0xAAAA, write 0x1234 with be=2'b01 -> read gives 0xAA34. With be=2'b00 -> ack, data unchanged.

Source files
------------

// File: rtl/mem_wait_ctrl_if.sv
// Request/response bus of mem_wait_ctrl. The req_be byte enables exist only when
// MEM_BYTE_WRITE_EN is defined.
interface mem_wait_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef MEM_BYTE_WRITE_EN
  logic [DATA_W/8-1:0] req_be;
`endif
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

`ifdef MEM_BYTE_WRITE_EN
  modport master (output req_valid, req_write, req_addr, req_wdata, req_be,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata, req_be,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
`else
  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
`endif
endinterface

// File: rtl/mem_wait_ctrl.sv
// Single-port word RAM with valid/ready requests, WAIT programmable wait states and a
// one-cycle response pulse. Define MEM_BYTE_WRITE_EN to enable per-byte write enables.
module mem_wait_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048,
  parameter int WAIT   = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_wait_ctrl_if.slave bus
);
  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_C  = 4'(WAIT);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef MEM_BYTE_WRITE_EN
  logic [NB-1:0]     be_q, be_d;
`endif
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept_s;
  logic              in_range_s;
  logic              do_write_s;
  logic [IDX_W-1:0]  idx_s;

  // Widened compare so DEPTH == 2**ADDR_W never reports out of range
  assign in_range_s = ({1'b0, addr_q} < DEPTH_C);
  assign idx_s      = addr_q[IDX_W-1:0];
  assign accept_s   = bus.req_valid && (state_q == S_IDLE);
  assign do_write_s = (state_q == S_ACCESS) && write_q && in_range_s && !rst;

  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Next-state, request latch and response computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef MEM_BYTE_WRITE_EN
    be_d        = be_q;
`endif
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef MEM_BYTE_WRITE_EN
          be_d    = bus.req_be;
`endif
          if (WAIT_C == 4'd0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_C;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACCESS;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACCESS: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !in_range_s;
        if (!write_q) begin
          rsp_rdata_d = in_range_s ? mem_q[idx_s] : {DATA_W{1'b0}};
        end else begin
          rsp_rdata_d = rsp_rdata_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request latch and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
`ifdef MEM_BYTE_WRITE_EN
      be_q        <= {NB{1'b0}};
`endif
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef MEM_BYTE_WRITE_EN
      be_q        <= be_d;
`endif
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM array, deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (do_write_s) begin
`ifdef MEM_BYTE_WRITE_EN
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) begin
          mem_q[idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
`else
      mem_q[idx_s] <= wdata_q;
`endif
    end
  end
endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Self-checking bench for mem_wait_ctrl: two instances (WAIT=2 with DEPTH < 2**ADDR_W,
// WAIT=0 with DEPTH == 2**ADDR_W) checked against a word-level memory model.
module tb_mem_wait_ctrl;
  localparam int DW     = 16;
  localparam int AW_A   = 11;
  localparam int DEPTH_A = 64;
  localparam int WAIT_A = 2;
  localparam int AW_B   = 6;
  localparam int DEPTH_B = 64;
  localparam int WAIT_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] model [int];
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;

  mem_wait_ctrl_if #(.DATA_W(DW), .ADDR_W(AW_A)) bus_a ();
  mem_wait_ctrl_if #(.DATA_W(DW), .ADDR_W(AW_B)) bus_b ();

  mem_wait_ctrl #(.DATA_W(DW), .ADDR_W(AW_A), .DEPTH(DEPTH_A), .WAIT(WAIT_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  mem_wait_ctrl #(.DATA_W(DW), .ADDR_W(AW_B), .DEPTH(DEPTH_B), .WAIT(WAIT_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic wr, input int addr,
                       input logic [15:0] d, input logic [1:0] be);
    if (w == 0) begin
      bus_a.req_valid = v; bus_a.req_write = wr;
      bus_a.req_addr = AW_A'(addr); bus_a.req_wdata = d;
`ifdef MEM_BYTE_WRITE_EN
      bus_a.req_be = be;
`endif
    end else begin
      bus_b.req_valid = v; bus_b.req_write = wr;
      bus_b.req_addr = AW_B'(addr); bus_b.req_wdata = d;
`ifdef MEM_BYTE_WRITE_EN
      bus_b.req_be = be;
`endif
    end
  endtask

  task automatic sample(input int w, output logic v, output logic [15:0] rd,
                        output logic er, output logic rdy, output logic bsy);
    if (w == 0) begin
      v = bus_a.rsp_valid; rd = bus_a.rsp_rdata; er = bus_a.rsp_err;
      rdy = bus_a.req_ready; bsy = bus_a.busy;
    end else begin
      v = bus_b.rsp_valid; rd = bus_b.rsp_rdata; er = bus_b.rsp_err;
      rdy = bus_b.req_ready; bsy = bus_b.busy;
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0] = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  function automatic logic [1:0] eff_be(input logic [1:0] be);
`ifdef MEM_BYTE_WRITE_EN
    return be;
`else
    return be | 2'b11;
`endif
  endfunction

  // Expected response of one request, updating the reference memory
  task automatic model_req(input int w, input logic wr, input int addr, input logic [15:0] d,
                           input logic [1:0] be, output logic [15:0] exp_rd, output logic exp_er);
    int key = w * 4096 + addr;
    int dp  = (w == 0) ? DEPTH_A : DEPTH_B;
    exp_er = (addr >= dp);
    if (wr) begin
      if (!exp_er) model[key] = merge(model.exists(key) ? model[key] : 16'h0000, d, eff_be(be));
      exp_rd = last_rd[w];
    end else begin
      exp_rd = exp_er ? 16'h0000 : model[key];
    end
    last_rd[w] = exp_rd;
  endtask

  task automatic xact(input int w, input logic wr, input int addr, input logic [15:0] d,
                      input logic [1:0] be, input string tag);
    logic v, er, rdy, bsy, exp_er;
    logic [15:0] rd, exp_rd;
    int seen = 0;
    int wt = (w == 0) ? WAIT_A : WAIT_B;
    @(negedge clk);
    sample(w, v, rd, er, rdy, bsy);
    check({tag, " ready_before"}, rdy, 1);
    drive(w, 1'b1, wr, addr, d, be);
    @(negedge clk);
    drive(w, 1'b0, 1'b0, 0, 16'h0000, 2'b00);
    model_req(w, wr, addr, d, be, exp_rd, exp_er);
    for (int k = 1; k <= 40; k++) begin
      sample(w, v, rd, er, rdy, bsy);
      if (k == 1) check({tag, " busy"}, bsy, 1);
      if (v) begin
        seen = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, " latency"}, seen, wt + 2);
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " err"}, er, exp_er);
    @(negedge clk);
    sample(w, v, rd, er, rdy, bsy);
    check({tag, " pulse_end"}, v, 0);
    check({tag, " hold_rdata"}, rd, exp_rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, er, rdy, bsy, any_v;
    logic [15:0] rd;
    logic wr;
    logic [1:0] be;
    int w, addr;

    drive(0, 1'b0, 1'b0, 0, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, 0, 16'h0000, 2'b00);
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sample(i, v, rd, er, rdy, bsy);
      check("rst rsp_valid", v, 0);
      check("rst rdata", rd, 0);
      check("rst err", er, 0);
      check("rst busy", bsy, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sample(i, v, rd, er, rdy, bsy);
      check("post_rst ready", rdy, 1);
    end

    // Write then read with two wait states
    xact(0, 1'b1, 21, 16'h1815, 2'b11, "w21");
    xact(0, 1'b0, 21, 16'h0000, 2'b11, "r21");
    check("r21 const", last_rd[0], 16'h1815);

    // Range boundaries on DEPTH=64
    xact(0, 1'b1, 0, 16'h0A0A, 2'b11, "w0");
    xact(0, 1'b1, 63, 16'h6363, 2'b11, "w63");
    xact(0, 1'b1, 64, 16'hBEEF, 2'b11, "w64_oor");
    xact(0, 1'b0, 0, 16'h0000, 2'b11, "r0");
    xact(0, 1'b0, 63, 16'h0000, 2'b11, "r63");
    xact(0, 1'b0, 64, 16'h0000, 2'b11, "r64_oor");
    xact(0, 1'b0, 2047, 16'h0000, 2'b11, "r2047_oor");

    // Zero wait states, full address space
    xact(1, 1'b1, 10, 16'h0009, 2'b11, "b_w10");
    xact(1, 1'b1, 11, 16'hFFFC, 2'b11, "b_w11");
    xact(1, 1'b1, 63, 16'h3F3F, 2'b11, "b_w63");
    xact(1, 1'b0, 63, 16'h0000, 2'b11, "b_r63");

    // Back-to-back reads, one response every two cycles
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 10, 16'h0000, 2'b11);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 11, 16'h0000, 2'b11);
    sample(1, v, rd, er, rdy, bsy);
    check("b2b n1 valid", v, 0);
    check("b2b n1 ready", rdy, 0);
    @(negedge clk);
    sample(1, v, rd, er, rdy, bsy);
    check("b2b n2 valid", v, 1);
    check("b2b n2 rdata", rd, 16'h0009);
    check("b2b n2 ready", rdy, 1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 0, 16'h0000, 2'b00);
    sample(1, v, rd, er, rdy, bsy);
    check("b2b n3 valid", v, 0);
    @(negedge clk);
    sample(1, v, rd, er, rdy, bsy);
    check("b2b n4 valid", v, 1);
    check("b2b n4 rdata", rd, 16'hFFFC);
    last_rd[1] = 16'hFFFC;

    // Request held while busy with address changed mid-flight
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 7, 16'h7777, 2'b11);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8, 16'h8888, 2'b11);
    for (int k = 1; k <= 8; k++) begin
      sample(0, v, rd, er, rdy, bsy);
      if (k == 1) begin
        check("hold busy", bsy, 1);
        check("hold ready", rdy, 0);
      end
      check($sformatf("hold rsp k%0d", k), v, (k == 4 || k == 8) ? 1 : 0);
      if (k == 4) check("hold ready_on_rsp", rdy, 1);
      if (k == 5) drive(0, 1'b0, 1'b0, 0, 16'h0000, 2'b00);
      @(negedge clk);
    end
    model[7] = 16'h7777;
    model[8] = 16'h8888;
    xact(0, 1'b0, 7, 16'h0000, 2'b11, "hold r7");
    xact(0, 1'b0, 8, 16'h0000, 2'b11, "hold r8");

    // Reset during WAIT of a pending write
    xact(0, 1'b1, 5, 16'h0055, 2'b11, "w5_old");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 5, 16'h1234, 2'b11);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 0, 16'h0000, 2'b00);
    #1 rst = 1'b1;
    #1;
    sample(0, v, rd, er, rdy, bsy);
    check("abort busy", bsy, 0);
    check("abort valid", v, 0);
    check("abort rdata", rd, 0);
    check("abort err", er, 0);
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    any_v = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sample(0, v, rd, er, rdy, bsy);
      any_v = any_v | v;
    end
    check("abort no_rsp", any_v, 0);
    xact(0, 1'b0, 5, 16'h0000, 2'b11, "abort r5");

`ifdef MEM_BYTE_WRITE_EN
    // Byte lane enables
    xact(0, 1'b1, 3, 16'hAAAA, 2'b11, "be w3");
    xact(0, 1'b1, 3, 16'h1234, 2'b01, "be w3_lo");
    xact(0, 1'b0, 3, 16'h0000, 2'b11, "be r3_lo");
    check("be const", last_rd[0], 16'hAA34);
    xact(0, 1'b1, 3, 16'h5678, 2'b00, "be w3_none");
    xact(0, 1'b0, 3, 16'h0000, 2'b11, "be r3_none");
`endif

    // Randomized mix on both instances
    for (int n = 0; n < 80; n++) begin
      w    = int'($urandom_range(0, 1));
      addr = (w == 0) ? int'($urandom_range(0, 90)) : int'($urandom_range(0, 63));
      wr   = 1'($urandom_range(0, 1));
      be   = 2'($urandom_range(0, 3));
      if (addr < 64 && !model.exists(w * 4096 + addr)) begin
        wr = 1'b1;
        be = 2'b11;
      end
      xact(w, wr, addr, 16'($urandom), be, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
